hamming_channel_injector: RTL and testbench

- Serial bit-error channel placed between main_encoder.dataout and main_decoder.datain.
- Passes the 15-bit Hamming(15,11) codeword stream through with one cycle of latency.
- Can flip selected bits inside each codeword, so the decoder's correction and detection paths can be exercised on purpose.
- Tracks codeword framing with its own bit counter and reports every injection.

---
 rtl/hamming_channel_injector.sv | 135 +++++++++++++
 tb/tb_hamming_channel_injector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_channel_injector.sv
// Serial bit-error channel between a Hamming(15,11) encoder and decoder.
// Passes the codeword stream through with one cycle of latency, optionally
// flipping one or two bits per codeword, and counts injected codewords.
module hamming_channel_injector #(
    parameter int unsigned CW_LEN    = 15,
    parameter int unsigned POS_W     = 4,
    parameter logic [3:0]  LFSR_SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             datain,
    input  logic             sof,
    input  logic [1:0]       mode,
    input  logic [POS_W-1:0] err_pos,
    output logic             dataout,
    output logic             err_flag,
    output logic [POS_W-1:0] bit_idx,
    output logic [15:0]      inj_count
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_RANDOM = 2'b10,
        MODE_DOUBLE = 2'b11
    } inj_mode_e;

    localparam logic [POS_W-1:0] LAST_IDX   = POS_W'(CW_LEN - 1);
    localparam logic [POS_W:0]   CW_LEN_EXT = (POS_W + 1)'(CW_LEN);

    logic [POS_W-1:0] idx_q, idx_d;
    logic [3:0]       lfsr_q, lfsr_d;
    inj_mode_e        act_mode_q, act_mode_d;
    logic [POS_W-1:0] act_pos_q, act_pos_d;
    logic             inj_seen_q, inj_seen_d;
    logic [15:0]      inj_count_q, inj_count_d;
    logic             dataout_q, dataout_d;
    logic             err_flag_q, err_flag_d;
    logic [POS_W-1:0] bit_idx_q, bit_idx_d;

    logic [POS_W-1:0] cur_idx;
    logic             start;
    inj_mode_e        eff_mode;
    logic [POS_W-1:0] eff_pos;
    logic             eff_seen;
    logic             pos_valid;
    logic [POS_W-1:0] pos_next;
    logic             flip;

    // Framing, per-codeword latch of mode/position, flip decision and next state.
    // Values latched at codeword start are used directly for bit 0 via eff_*.
    always_comb begin
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        act_mode_d  = act_mode_q;
        act_pos_d   = act_pos_q;
        inj_seen_d  = inj_seen_q;
        inj_count_d = inj_count_q;
        dataout_d   = dataout_q;
        err_flag_d  = err_flag_q;
        bit_idx_d   = bit_idx_q;

        cur_idx   = sof ? '0 : idx_q;
        start     = (cur_idx == '0);
        eff_mode  = act_mode_q;
        eff_pos   = act_pos_q;
        eff_seen  = inj_seen_q;
        pos_valid = 1'b0;
        pos_next  = '0;
        flip      = 1'b0;

        if (enable) begin
            if (start) begin
                eff_mode = inj_mode_e'(mode);
                eff_pos  = (eff_mode == MODE_RANDOM) ? POS_W'(lfsr_q - 4'd1) : err_pos;
                eff_seen = 1'b0;
                lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
            end

            pos_valid = ({1'b0, eff_pos} < CW_LEN_EXT);
            pos_next  = (eff_pos == LAST_IDX) ? '0 : eff_pos + POS_W'(1);

            unique case (eff_mode)
                MODE_PASS:   flip = 1'b0;
                MODE_SINGLE,
                MODE_RANDOM: flip = pos_valid && (cur_idx == eff_pos);
                MODE_DOUBLE: flip = pos_valid && ((cur_idx == eff_pos) || (cur_idx == pos_next));
            endcase

            idx_d      = (cur_idx == LAST_IDX) ? '0 : cur_idx + POS_W'(1);
            act_mode_d = eff_mode;
            act_pos_d  = eff_pos;
            inj_seen_d = eff_seen | flip;
            if (flip && !eff_seen && (inj_count_q != '1)) begin
                inj_count_d = inj_count_q + 16'd1;
            end

            dataout_d  = datain ^ flip;
            err_flag_d = flip;
            bit_idx_d  = cur_idx;
        end
    end

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            act_mode_q  <= MODE_PASS;
            act_pos_q   <= '0;
            inj_seen_q  <= 1'b0;
            inj_count_q <= '0;
            dataout_q   <= 1'b0;
            err_flag_q  <= 1'b0;
            bit_idx_q   <= '0;
        end else begin
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            act_mode_q  <= act_mode_d;
            act_pos_q   <= act_pos_d;
            inj_seen_q  <= inj_seen_d;
            inj_count_q <= inj_count_d;
            dataout_q   <= dataout_d;
            err_flag_q  <= err_flag_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

    assign dataout   = dataout_q;
    assign err_flag  = err_flag_q;
    assign bit_idx   = bit_idx_q;
    assign inj_count = inj_count_q;

endmodule

// File: tb/tb_hamming_channel_injector.sv
// Scoreboard bench for hamming_channel_injector: directed scenarios followed
// by randomized traffic, checked against a behavioural channel model.
module tb_hamming_channel_injector;

    logic        clk = 1'b0;
    logic        reset, enable, datain, sof;
    logic [1:0]  mode;
    logic [3:0]  err_pos;
    logic        dataout, err_flag;
    logic [3:0]  bit_idx;
    logic [15:0] inj_count;

    typedef struct packed {
        logic        dout;
        logic        ef;
        logic [3:0]  idx;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // behavioural channel model state
    int m_idx, m_lfsr, m_mode, m_pos, m_count;
    bit m_seen;

    hamming_channel_injector #(
        .CW_LEN   (15),
        .POS_W    (4),
        .LFSR_SEED(4'b0001)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .datain   (datain),
        .sof      (sof),
        .mode     (mode),
        .err_pos  (err_pos),
        .dataout  (dataout),
        .err_flag (err_flag),
        .bit_idx  (bit_idx),
        .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idx = 0; m_lfsr = 1; m_mode = 0; m_pos = 0; m_count = 0; m_seen = 0;
    endtask

    // Apply one cycle of inputs at the falling edge and predict its result.
    task automatic step(input logic r, input logic e, input logic s, input logic d,
                        input logic [1:0] m, input logic [3:0] p);
        int   c;
        bit   flip;
        exp_t x;
        @(negedge clk);
        reset = r; enable = e; sof = s; datain = d; mode = m; err_pos = p;
        if (r) begin
            model_reset();
        end else if (e) begin
            c = s ? 0 : m_idx;
            if (c == 0) begin
                m_mode = int'(m);
                m_pos  = (m == 2'b10) ? m_lfsr - 1 : int'(p);
                m_lfsr = ((m_lfsr << 1) & 15) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
                m_seen = 0;
            end
            flip = 0;
            if (m_pos < 15) begin
                if (m_mode == 1 || m_mode == 2) flip = (c == m_pos);
                else if (m_mode == 3)           flip = (c == m_pos) || (c == (m_pos + 1) % 15);
            end
            if (flip && !m_seen) begin
                m_seen = 1;
                if (m_count < 65535) m_count++;
            end
            x.dout = d ^ flip;
            x.ef   = flip;
            x.idx  = 4'(c);
            x.cnt  = 16'(m_count);
            q.push_back(x);
            m_idx = (c + 1) % 15;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic check_const(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: after each edge, compare outputs to the scoreboard entry
    // (enabled edge), all-zero (reset edge) or the previous value (hold).
    logic last_rst = 1'b0;
    logic last_en  = 1'b0;
    exp_t last_exp = '0;

    always @(posedge clk) begin
        last_rst <= reset;
        last_en  <= enable;
    end

    always @(negedge clk) begin : monitor
        exp_t  got, want;
        string nm;
        got = {dataout, err_flag, bit_idx, inj_count};
        if (last_rst) begin
            want = '0;
            nm   = "reset_state";
        end else if (last_en) begin
            nm = "stream_bit";
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: output present with no expected entry");
                want = last_exp;
            end else begin
                want = q.pop_front();
            end
        end else begin
            want = last_exp;
            nm   = "hold";
        end
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got dout=%b ef=%b idx=%0d cnt=%0d expected dout=%b ef=%b idx=%0d cnt=%0d",
                     nm, got.dout, got.ef, got.idx, got.cnt, want.dout, want.ef, want.idx, want.cnt);
        end
        last_exp = want;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [14:0] pat;
        reset = 1'b1; enable = 1'b0; sof = 1'b0; datain = 1'b0; mode = 2'b00; err_pos = 4'd0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 4'd0);

        // pass-through of a fixed pattern
        pat = 15'b110010100111010;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, i == 0, pat[14-i], 2'b00, 4'd0);
        idle();
        check_const("pass_inj_count", int'(inj_count), 0);
        check_const("pass_last_bit", int'(dataout), 0);

        // single error at position 5
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, i == 0, 1'b0, 2'b01, 4'd5);
        idle();
        check_const("single_inj_count", int'(inj_count), 1);

        // double error wrapping from 14 to 0, two codewords
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, i == 0, 1'b0, 2'b11, 4'd14);
        idle();
        check_const("double_inj_count", int'(inj_count), 2);

        // LFSR positions, four codewords
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, i == 0, 1'b0, 2'b10, 4'd0);
        idle();
        check_const("random_inj_count", int'(inj_count), 4);

        // enable gap at index 7, flip at 9
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i == 0, 1'b0, 2'b01, 4'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 4'd2);
        for (int i = 8; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        idle();
        check_const("gap_inj_count", int'(inj_count), 1);

        // reset mid-codeword, resume without sof
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i == 0, 1'b0, 2'b01, 4'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 4'd3);
        idle();
        check_const("abort_inj_count", int'(inj_count), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'd0);
        idle();
        check_const("abort_bit_idx", int'(bit_idx), 0);
        check_const("abort_seed_flip", int'(err_flag), 1);
        check_const("abort_dataout", int'(dataout), 1);
        for (int i = 1; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom),
                 2'($urandom),
                 4'($urandom_range(0, 15)));
        end

        idle();
        idle();
        check_const("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
